// File: rtl/axil_cmd_master.sv
// AXI4-lite initiator: one read or write per accepted command, result returned on a valid/ready port.
// All outputs are registered; a single transaction is in flight, AW and W handshake independently.
module axil_cmd_master #(
  parameter int C_M_AXI_ADDR_WIDTH = 4,
  parameter int C_M_AXI_DATA_WIDTH = 32
) (
  input  logic                              M_AXI_ACLK,
  input  logic                              M_AXI_ARESETN,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic                              cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                        rsp_resp,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTB,
  output logic                              M_AXI_WAVLID,
  input  logic                              M_AXI_WREADY,
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic                              M_AXI_ARVALID,
  input  logic                              M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                        M_AXI_RRESP,
  input  logic                              M_AXI_RVALID,
  output logic                              M_AXI_RREADY
);

  localparam int SW = C_M_AXI_DATA_WIDTH / 8;

  typedef enum logic [2:0] {IDLE, WRITE, WRESP, READ, RDATA, RESP} state_t;

  state_t state, next_state;

  logic aw_done, w_done;
  logic aw_fin, w_fin, cmd_fire, b_fire, r_fire;

  logic                          cmd_ready_d, rsp_valid_d;
  logic                          awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d;
  logic                          aw_done_d, w_done_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0] awaddr_d, araddr_d;
  logic [C_M_AXI_DATA_WIDTH-1:0] wdata_d, rdata_d;
  logic [SW-1:0]                 wstb_d;
  logic [1:0]                    resp_d;

  // A channel counts as finished if it handshook earlier or is handshaking now.
  assign aw_fin   = aw_done | (M_AXI_AWVALID & M_AXI_AWREADY);
  assign w_fin    = w_done  | (M_AXI_WAVLID & M_AXI_WREADY);
  assign cmd_fire = cmd_valid & cmd_ready;
  assign b_fire   = M_AXI_BVALID & M_AXI_BREADY;
  assign r_fire   = M_AXI_RVALID & M_AXI_RREADY;

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) state <= IDLE;
    else                state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (cmd_fire) next_state = cmd_write ? WRITE : READ;
      WRITE:   if (aw_fin && w_fin) next_state = WRESP;
      WRESP:   if (b_fire) next_state = RESP;
      READ:    if (M_AXI_ARVALID && M_AXI_ARREADY) next_state = RDATA;
      RDATA:   if (r_fire) next_state = RESP;
      RESP:    if (rsp_valid && rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Registered outputs are derived from the state being entered, so they line up with it.
  always_comb begin
    cmd_ready_d = (next_state == IDLE);
    awvalid_d   = (next_state == WRITE) && !aw_fin;
    wvalid_d    = (next_state == WRITE) && !w_fin;
    aw_done_d   = (next_state == WRITE) && aw_fin;
    w_done_d    = (next_state == WRITE) && w_fin;
    bready_d    = (next_state == WRESP);
    arvalid_d   = (next_state == READ);
    rready_d    = (next_state == RDATA);
    rsp_valid_d = (next_state == RESP);

    awaddr_d = M_AXI_AWADDR;
    wdata_d  = M_AXI_WDATA;
    wstb_d   = M_AXI_WSTB;
    araddr_d = M_AXI_ARADDR;
    rdata_d  = rsp_rdata;
    resp_d   = rsp_resp;

    if (state == IDLE && cmd_fire) begin
      if (cmd_write) begin
        awaddr_d = cmd_addr;
        wdata_d  = cmd_wdata;
        wstb_d   = cmd_wstrb;
      end else begin
        araddr_d = cmd_addr;
      end
    end

    if (state == WRESP && b_fire) begin
      rdata_d = '0;
      resp_d  = M_AXI_BRESP;
    end

    if (state == RDATA && r_fire) begin
      rdata_d = M_AXI_RDATA;
      resp_d  = M_AXI_RRESP;
    end
  end

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      cmd_ready     <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= 2'b00;
      M_AXI_AWADDR  <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WDATA   <= '0;
      M_AXI_WSTB    <= '0;
      M_AXI_WAVLID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARADDR  <= '0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
    end else begin
      cmd_ready     <= cmd_ready_d;
      rsp_valid     <= rsp_valid_d;
      rsp_rdata     <= rdata_d;
      rsp_resp      <= resp_d;
      M_AXI_AWADDR  <= awaddr_d;
      M_AXI_AWVALID <= awvalid_d;
      M_AXI_WDATA   <= wdata_d;
      M_AXI_WSTB    <= wstb_d;
      M_AXI_WAVLID  <= wvalid_d;
      M_AXI_BREADY  <= bready_d;
      M_AXI_ARADDR  <= araddr_d;
      M_AXI_ARVALID <= arvalid_d;
      M_AXI_RREADY  <= rready_d;
      aw_done       <= aw_done_d;
      w_done        <= w_done_d;
    end
  end

endmodule

// File: tb/tb_axil_cmd_master.sv
// Bench for axil_cmd_master: delay-configurable AXI4-lite slave with memory, directed scenarios
// and a randomized run compared against a word-array model and arithmetic latency rules.
module tb_axil_cmd_master;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          cmd_valid = 0, cmd_ready, cmd_write = 0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [SW-1:0] cmd_wstrb = '0;
  logic          rsp_valid, rsp_ready = 0;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [AW-1:0] M_AXI_AWADDR, M_AXI_ARADDR;
  logic          M_AXI_AWVALID, M_AXI_AWREADY = 0;
  logic [DW-1:0] M_AXI_WDATA;
  logic [SW-1:0] M_AXI_WSTB;
  logic          M_AXI_WAVLID, M_AXI_WREADY = 0;
  logic [1:0]    M_AXI_BRESP = 0;
  logic          M_AXI_BVALID = 0, M_AXI_BREADY;
  logic          M_AXI_ARVALID, M_AXI_ARREADY = 0;
  logic [DW-1:0] M_AXI_RDATA = '0;
  logic [1:0]    M_AXI_RRESP = 0;
  logic          M_AXI_RVALID = 0, M_AXI_RREADY;

  axil_cmd_master #(.C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_DATA_WIDTH(DW)) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTB(M_AXI_WSTB), .M_AXI_WAVLID(M_AXI_WAVLID),
    .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID),
    .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID),
    .M_AXI_ARREADY(M_AXI_ARREADY), .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  logic [2*DW+2*AW+2*1+SW+2+7-1:0] all_out;
  assign all_out = {cmd_ready, rsp_valid, rsp_rdata, rsp_resp, M_AXI_AWADDR, M_AXI_AWVALID,
                    M_AXI_WDATA, M_AXI_WSTB, M_AXI_WAVLID, M_AXI_BREADY, M_AXI_ARADDR,
                    M_AXI_ARVALID, M_AXI_RREADY};

  int n_checks = 0;
  int n_fail = 0;

  // Slave configuration and storage; model_mem is the bench's independent view of memory.
  int         aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0] bresp_cfg = 0, rresp_cfg = 0;
  logic [DW-1:0] slave_mem [4];
  logic [DW-1:0] model_mem [4];

  int            aw_wait = 0, w_wait = 0, ar_wait = 0, b_wait = 0, r_wait = 0;
  bit            aw_got = 0, w_got = 0, ar_got = 0, b_hs = 0, r_hs = 0;
  logic [AW-1:0] aw_cap = '0, ar_cap = '0;
  logic [DW-1:0] w_cap = '0;
  logic [SW-1:0] s_cap = '0;

  // Handshakes are predicted at the falling edge for the following rising edge.
  initial begin : slave
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
        aw_got = 0; w_got = 0; ar_got = 0; b_hs = 0; r_hs = 0;
        M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_ARREADY = 0;
        M_AXI_BVALID = 0; M_AXI_RVALID = 0;
      end else begin
        if (b_hs) begin M_AXI_BVALID = 0; b_hs = 0; aw_got = 0; w_got = 0; b_wait = 0; end
        if (r_hs) begin M_AXI_RVALID = 0; r_hs = 0; ar_got = 0; r_wait = 0; end
        if (aw_got && w_got && !M_AXI_BVALID) begin
          if (b_wait >= b_dly) begin
            for (int i = 0; i < SW; i++)
              if (s_cap[i]) slave_mem[aw_cap[3:2]][8*i +: 8] = w_cap[8*i +: 8];
            M_AXI_BVALID = 1; M_AXI_BRESP = bresp_cfg;
          end else b_wait++;
        end
        if (ar_got && !M_AXI_RVALID) begin
          if (r_wait >= r_dly) begin
            M_AXI_RVALID = 1; M_AXI_RDATA = slave_mem[ar_cap[3:2]]; M_AXI_RRESP = rresp_cfg;
          end else r_wait++;
        end
        M_AXI_AWREADY = M_AXI_AWVALID && (aw_wait >= aw_dly);
        M_AXI_WREADY  = M_AXI_WAVLID && (w_wait >= w_dly);
        M_AXI_ARREADY = M_AXI_ARVALID && (ar_wait >= ar_dly);
        if (M_AXI_AWVALID) aw_wait++; else aw_wait = 0;
        if (M_AXI_WAVLID)  w_wait++;  else w_wait = 0;
        if (M_AXI_ARVALID) ar_wait++; else ar_wait = 0;
        if (M_AXI_AWVALID && M_AXI_AWREADY) begin aw_got = 1; aw_cap = M_AXI_AWADDR; end
        if (M_AXI_WAVLID && M_AXI_WREADY) begin w_got = 1; w_cap = M_AXI_WDATA; s_cap = M_AXI_WSTB; end
        if (M_AXI_ARVALID && M_AXI_ARREADY) begin ar_got = 1; ar_cap = M_AXI_ARADDR; end
        b_hs = M_AXI_BVALID && M_AXI_BREADY;
        r_hs = M_AXI_RVALID && M_AXI_RREADY;
      end
    end
  end

  // Channel activity statistics, cleared by each scenario.
  int aw_cyc, w_cyc, ar_cyc, aw_unstable, w_unstable, ar_unstable, bready_early, rready_early;
  logic aw_prev = 0, w_prev = 0, ar_prev = 0;
  logic [AW-1:0] aw_last = '0, ar_last = '0;
  logic [DW+SW-1:0] w_last = '0;

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (M_AXI_AWVALID) begin
        if (aw_prev && M_AXI_AWADDR !== aw_last) aw_unstable++;
        aw_cyc++; aw_last = M_AXI_AWADDR;
      end
      if (M_AXI_WAVLID) begin
        if (w_prev && {M_AXI_WDATA, M_AXI_WSTB} !== w_last) w_unstable++;
        w_cyc++; w_last = {M_AXI_WDATA, M_AXI_WSTB};
      end
      if (M_AXI_ARVALID) begin
        if (ar_prev && M_AXI_ARADDR !== ar_last) ar_unstable++;
        ar_cyc++; ar_last = M_AXI_ARADDR;
      end
      aw_prev = M_AXI_AWVALID; w_prev = M_AXI_WAVLID; ar_prev = M_AXI_ARVALID;
      if (M_AXI_BREADY && (M_AXI_AWVALID || M_AXI_WAVLID)) bready_early++;
      if (M_AXI_RREADY && M_AXI_ARVALID) rready_early++;
    end
  end

  task automatic clear_mon();
    aw_cyc = 0; w_cyc = 0; ar_cyc = 0; aw_unstable = 0; w_unstable = 0; ar_unstable = 0;
    bready_early = 0; rready_early = 0;
  endtask

  task automatic model_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
    for (int i = 0; i < SW; i++)
      if (s[i]) model_mem[a[3:2]][8*i +: 8] = d[8*i +: 8];
  endtask

  // Drives one command from a falling edge and returns the response; lat counts falling edges
  // from the accept edge to the first one with rsp_valid high.
  task automatic do_cmd(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [SW-1:0] s, input int hold,
                        output logic [DW-1:0] rd, output logic [1:0] rr, output int lat, output bit to);
    int n;
    to = 0; lat = 0; rd = '0; rr = '0;
    cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    if (!cmd_ready) begin to = 1; cmd_valid = 0; return; end
    @(negedge clk);
    cmd_valid = 0;
    lat = 1;
    while (!rsp_valid && lat < 200) begin @(negedge clk); lat++; end
    if (!rsp_valid) begin to = 1; return; end
    rd = rsp_rdata; rr = rsp_resp;
    repeat (hold) @(negedge clk);
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
  endtask

  task automatic test_reset();
    #1;
    n_checks++; if (all_out !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h exp 0", all_out); end
    @(negedge clk);
    rst_n = 1;
    #1;
    n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL ready_before_edge: got %b exp 0", cmd_ready); end
    @(negedge clk);
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_edge: got %b exp 1", cmd_ready); end
  endtask

  task automatic test_basic_write();
    logic [DW-1:0] rd; logic [1:0] rr; int lat; bit to;
    clear_mon();
    do_cmd(1, 4'h4, 32'hA5A50001, 4'hF, 0, rd, rr, lat, to);
    model_write(4'h4, 32'hA5A50001, 4'hF);
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL wr_timeout: got %b exp 0", to); end
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL wr_latency: got %0d exp 3", lat); end
    n_checks++; if ({rr, rd} !== 34'h0) begin n_fail++; $display("FAIL wr_rsp: got %h/%h exp 0/0", rr, rd); end
    n_checks++; if (aw_cyc !== 1 || w_cyc !== 1) begin n_fail++; $display("FAIL wr_valid_cycles: got aw=%0d w=%0d exp 1/1", aw_cyc, w_cyc); end
    n_checks++; if ({rsp_valid, cmd_ready} !== 2'b01) begin n_fail++; $display("FAIL wr_after_rsp: got %b exp 01", {rsp_valid, cmd_ready}); end
  endtask

  task automatic test_aw_delay();
    logic [DW-1:0] rd; logic [1:0] rr; int lat; bit to;
    clear_mon();
    aw_dly = 3;
    do_cmd(1, 4'h4, 32'h0BADBEEF, 4'h3, 0, rd, rr, lat, to);
    model_write(4'h4, 32'h0BADBEEF, 4'h3);
    aw_dly = 0;
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL awdly_timeout: got %b exp 0", to); end
    n_checks++; if (aw_cyc !== 4 || w_cyc !== 1) begin n_fail++; $display("FAIL awdly_cycles: got aw=%0d w=%0d exp 4/1", aw_cyc, w_cyc); end
    n_checks++; if (aw_unstable !== 0 || aw_last !== 4'h4) begin n_fail++; $display("FAIL awdly_addr: got unstable=%0d addr=%h exp 0/4", aw_unstable, aw_last); end
    n_checks++; if (bready_early !== 0) begin n_fail++; $display("FAIL awdly_bready: got %0d early cycles exp 0", bready_early); end
    n_checks++; if (lat !== 6) begin n_fail++; $display("FAIL awdly_latency: got %0d exp 6", lat); end
  endtask

  task automatic test_read();
    logic [DW-1:0] rd; logic [1:0] rr; int lat; bit to;
    clear_mon();
    slave_mem[2] = 32'h12345678; model_mem[2] = 32'h12345678;
    ar_dly = 2;
    do_cmd(0, 4'h8, '0, '0, 0, rd, rr, lat, to);
    ar_dly = 0;
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL rd_timeout: got %b exp 0", to); end
    n_checks++; if (rd !== 32'h12345678 || rr !== 2'b00) begin n_fail++; $display("FAIL rd_data: got %h/%h exp 12345678/0", rd, rr); end
    n_checks++; if (rready_early !== 0 || ar_cyc !== 3) begin n_fail++; $display("FAIL rd_channel: got rready_early=%0d ar=%0d exp 0/3", rready_early, ar_cyc); end
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL rd_latency: got %0d exp 5", lat); end
  endtask

  task automatic test_error_resp();
    logic [DW-1:0] rd; logic [1:0] rr; int lat; bit to;
    rresp_cfg = 2'b10;
    do_cmd(0, 4'hC, '0, '0, 0, rd, rr, lat, to);
    n_checks++; if ({to, rr, rd} !== {1'b0, 2'b10, model_mem[3]}) begin n_fail++; $display("FAIL slverr_read: got %b/%h/%h exp 0/2/%h", to, rr, rd, model_mem[3]); end
    bresp_cfg = 2'b11;
    do_cmd(1, 4'h0, 32'h11223344, 4'h0, 0, rd, rr, lat, to);
    n_checks++; if ({to, rr, rd} !== {1'b0, 2'b11, 32'h0}) begin n_fail++; $display("FAIL decerr_write: got %b/%h/%h exp 0/3/0", to, rr, rd); end
    rresp_cfg = 0; bresp_cfg = 0;
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL decerr_latency: got %0d exp 3", lat); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] exp; int n;
    exp = model_mem[1];
    cmd_write = 0; cmd_addr = 4'h5; cmd_valid = 1;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    cmd_write = 1; cmd_addr = 4'hC; cmd_wdata = 32'hCAFEF00D; cmd_wstrb = 4'hF;
    n = 0;
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_rsp_timeout: got %b exp 1", rsp_valid); end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({rsp_valid, rsp_rdata, cmd_ready, M_AXI_AWVALID, M_AXI_WAVLID, M_AXI_ARVALID} !== {1'b1, exp, 4'b0000}) begin
        n_fail++;
        $display("FAIL bp_stall_%0d: got v=%b d=%h rdy=%b aw=%b w=%b ar=%b exp v=1 d=%h rest 0",
                 i, rsp_valid, rsp_rdata, cmd_ready, M_AXI_AWVALID, M_AXI_WAVLID, M_AXI_ARVALID, exp);
      end
      @(negedge clk);
    end
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    n_checks++; if ({rsp_valid, cmd_ready} !== 2'b01) begin n_fail++; $display("FAIL bp_release: got %b exp 01", {rsp_valid, cmd_ready}); end
    @(negedge clk);
    cmd_valid = 0;
    n_checks++; if ({M_AXI_AWVALID, M_AXI_WAVLID, cmd_ready} !== 3'b110) begin n_fail++; $display("FAIL bp_second_accept: got %b exp 110", {M_AXI_AWVALID, M_AXI_WAVLID, cmd_ready}); end
    model_write(4'hC, 32'hCAFEF00D, 4'hF);
    n = 0;
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    n_checks++; if ({rsp_valid, rsp_resp} !== 3'b100) begin n_fail++; $display("FAIL bp_second_rsp: got %b exp 100", {rsp_valid, rsp_resp}); end
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] rd; logic [1:0] rr; int lat; bit to; int n;
    aw_dly = 1000;
    cmd_write = 1; cmd_addr = 4'h8; cmd_wdata = 32'hDEADDEAD; cmd_wstrb = 4'hF; cmd_valid = 1;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    cmd_valid = 0;
    @(negedge clk);
    n_checks++; if (M_AXI_AWVALID !== 1'b1) begin n_fail++; $display("FAIL mid_awvalid: got %b exp 1", M_AXI_AWVALID); end
    #2 rst_n = 0;
    #1;
    n_checks++; if (all_out !== '0) begin n_fail++; $display("FAIL mid_async_reset: got %h exp 0", all_out); end
    repeat (2) @(negedge clk);
    aw_dly = 0;
    rst_n = 1;
    @(negedge clk);
    n_checks++; if ({cmd_ready, rsp_valid, M_AXI_AWVALID} !== 3'b100) begin n_fail++; $display("FAIL mid_restart: got %b exp 100", {cmd_ready, rsp_valid, M_AXI_AWVALID}); end
    do_cmd(1, 4'h8, 32'h600DF00D, 4'hF, 0, rd, rr, lat, to);
    model_write(4'h8, 32'h600DF00D, 4'hF);
    n_checks++; if ({to, rr, lat} !== {1'b0, 2'b00, 32'd3}) begin n_fail++; $display("FAIL mid_new_write: got to=%b resp=%h lat=%0d exp 0/0/3", to, rr, lat); end
    do_cmd(0, 4'h8, '0, '0, 0, rd, rr, lat, to);
    n_checks++; if (rd !== model_mem[2]) begin n_fail++; $display("FAIL mid_readback: got %h exp %h", rd, model_mem[2]); end
  endtask

  task automatic test_random();
    logic [DW-1:0] rd, d, exp_d; logic [1:0] rr, exp_r; logic [AW-1:0] a; logic [SW-1:0] s;
    int lat, exp_lat, exp_aw, exp_w, exp_ar; bit to, wr;
    clear_mon();
    exp_aw = 0; exp_w = 0; exp_ar = 0;
    for (int t = 0; t < 40; t++) begin
      wr = 1'($urandom_range(0, 1));
      a = AW'($urandom_range(0, 15));
      d = $urandom;
      s = SW'($urandom_range(0, 15));
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 2);
      ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 2);
      bresp_cfg = 2'($urandom_range(0, 3)); rresp_cfg = 2'($urandom_range(0, 3));
      if (wr) begin
        exp_d = '0; exp_r = bresp_cfg;
        exp_lat = 3 + ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly;
        exp_aw += aw_dly + 1; exp_w += w_dly + 1;
      end else begin
        exp_d = model_mem[a[3:2]]; exp_r = rresp_cfg;
        exp_lat = 3 + ar_dly + r_dly;
        exp_ar += ar_dly + 1;
      end
      do_cmd(wr, a, d, s, $urandom_range(0, 2), rd, rr, lat, to);
      if (wr) model_write(a, d, s);
      n_checks++;
      if ({to, rr, rd} !== {1'b0, exp_r, exp_d} || lat !== exp_lat) begin
        n_fail++;
        $display("FAIL rand_%0d: wr=%b addr=%h got to=%b resp=%h data=%h lat=%0d exp resp=%h data=%h lat=%0d",
                 t, wr, a, to, rr, rd, lat, exp_r, exp_d, exp_lat);
      end
    end
    aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0; bresp_cfg = 0; rresp_cfg = 0;
    n_checks++; if (aw_cyc !== exp_aw || w_cyc !== exp_w || ar_cyc !== exp_ar) begin n_fail++; $display("FAIL rand_valid_cycles: got %0d/%0d/%0d exp %0d/%0d/%0d", aw_cyc, w_cyc, ar_cyc, exp_aw, exp_w, exp_ar); end
    n_checks++; if (aw_unstable + w_unstable + ar_unstable + bready_early + rready_early !== 0) begin n_fail++; $display("FAIL rand_protocol: got %0d/%0d/%0d/%0d/%0d exp all 0", aw_unstable, w_unstable, ar_unstable, bready_early, rready_early); end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      slave_mem[i] = 32'h1000_0000 * (i + 1) + 32'h00AB_CD00;
      model_mem[i] = slave_mem[i];
    end
    test_reset();
    test_basic_write();
    test_aw_delay();
    test_read();
    test_error_resp();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
